imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the ID stage. It decodes all RV32I/RV64I immediate formats (I, S, B, U, J, shift-amount, CSR zimm) and sign-extends them to XLEN. For branch, jump and AUIPC it also computes the PC-relative target. A registered output stage with a valid/ready handshake, a 2-entry skid buffer and a flush decouples it from the fetch and execute stages.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discard all buffered beats (branch mispredict / trap).
- in_valid_i  in  1  instr_i and pc_i valid.
- in_ready_o  out  1  block can accept a beat; registered.
- instr_i  in  32  raw instruction word.
- pc_i  in  XLEN  PC of instr_i.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer accepts the output beat.
- imm_o  out  XLEN  extended immediate.
- fmt_o  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM.
- target_o  out  XLEN  pc+imm for B, J and AUIPC; 0 otherwise.
- illegal_o  out  1  opcode or field not decodable.

## Operation
- Opcode 0000011 (load), 0001111 (fence), 1100111 (jalr) -> I: imm = sext(instr[31:20]).
- Opcode 0010011 (OP-IMM):
  - funct3 001 or 101 -> SHAMT. For XLEN=32, imm = zext(instr[24:20]), and instr[25]=1 is illegal. For XLEN=64, imm = zext(instr[25:20]).
  - Any other funct3 -> I.
- Opcode 1110011 (system):
  - funct3[2]=1 -> ZIMM: imm = zext(instr[19:15]).
  - Otherwise -> I.
- Opcode 0100011 -> S: sext({instr[31:25], instr[11:7]}).
- Opcode 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- Opcode 0110111 / 0010111 -> U: sext({instr[31:12], 12'b0}).
- Opcode 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Opcode 0110011 (R) -> NONE, imm 0.
- Any other opcode, or instr[1:0] != 11 -> illegal_o=1, fmt NONE, imm 0, target 0.
- target_o = (pc_i + imm) mod 2^XLEN, computed only for B, J and AUIPC (0010111). It is 0 for every other instruction, including LUI and JALR.
- Storage is 2 entries: an output register plus a skid register.
  - A beat is accepted when in_valid_i & in_ready_o.
  - Beats leave the block in the order they were accepted.
- in_ready_o = skid entry empty. It is computed from registered state only.
- Output stability: while out_valid_o=1 and out_ready_i=0, all output data is held unchanged.
- Input rule: once in_valid_i is asserted, it is held with stable data until accepted. A bench assertion enforces this.
- flush_i:
  - Empties both entries at the next edge.
  - Any beat offered in the same cycle is dropped.
  - Flush takes priority over accept and over drain.
- rst_i has the same state effect as flush_i and also zeroes the data registers.

## Timing
- Reset values: out_valid_o=0, imm_o=0, fmt_o=0, target_o=0, illegal_o=0, in_ready_o=0. in_ready_o returns to 1 the cycle after rst_i deasserts.
- Latency: a beat accepted at edge N is on the outputs with out_valid_o=1 after edge N.
- Throughput: 1 beat/cycle while out_ready_i=1.
- Output register empty or draining: an incoming beat goes directly to the output register.
- Output stalled: the incoming beat goes to the skid register, and in_ready_o drops after that edge.
- Skid full and out_ready_i=1: the skid entry moves to the output register and in_ready_o rises after that edge.
- Simultaneous accept and drain with the skid empty: the output register reloads, and out_valid_o stays 1 with no bubble.
- Flush in the same cycle as out_ready_i=1: the output beat counts as consumed and nothing survives.
- Reset mid-stream: same as flush, and no partial beat appears afterwards.

## Structure
- Package imm_gen_pkg:
  - fmt enum (NONE..ZIMM).
  - opcode localparams (LOAD, OP_IMM, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OP, FENCE).
- Sub-module imm_decode: purely combinational, parameterised by XLEN, and produces imm, fmt, illegal and is_pcrel.
- imm_gen_pipe contains the target adder, the skid buffer and the handshake logic.

## Test plan
- lw x1,-4(x2): instr 0xFFC12083, pc 0x100 -> one cycle later imm 0xFFFFFFFC, fmt 1, target 0, illegal 0.
- beq x0,x0,-8: instr 0xFE000CE3, pc 0x200 -> imm 0xFFFFFFF8, fmt 3, target 0x1F8.
- auipc x5,0x12345: instr 0x12345297, pc 0x1000 -> imm 0x12345000, fmt 4, target 0x12346000. lui 0x12345 (0x123452B7) -> target 0.
- slli x1,x1,63: instr 0x03F09093 -> with XLEN=64, imm 63, fmt 6. With XLEN=32, illegal 1. Opcode 0x0000007F -> illegal 1, imm 0.
- 4 back-to-back beats with out_ready_i held low for 3 cycles -> in_ready_o low after 2 accepts, no loss, in-order delivery, outputs stable during the stall.
- flush_i with 2 beats buffered and in_valid_i high -> out_valid_o=0 and in_ready_o=1 next cycle; the 3 flushed beats never appear.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the ID-stage immediate generator.
// Imported by imm_decode and imm_gen_pipe.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder.
// Produces the XLEN-extended immediate, its format, an illegal flag, and a PC-relative hint.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output fmt_e            fmt_o,
  output logic            illegal_o,
  output logic            is_pcrel_o
);

  logic [XLEN-1:0] imm;
  fmt_e            fmt;
  logic            ill;
  logic            pcrel;

  always_comb begin
    imm   = '0;
    fmt   = FMT_NONE;
    ill   = 1'b0;
    pcrel = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (instr_i[6:0])
        LOAD, FENCE, JALR: begin
          fmt = FMT_I;
          imm = XLEN'($signed(instr_i[31:20]));
        end
        OP_IMM: begin
          // funct3 001 (SLLI) and 101 (SRLI/SRAI) share funct3[1:0] == 01
          if (instr_i[13:12] == 2'b01) begin
            fmt = FMT_SHAMT;
            if (XLEN == 32) begin
              ill = instr_i[25];
              imm = XLEN'(instr_i[24:20]);
            end else begin
              imm = XLEN'(instr_i[25:20]);
            end
          end else begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr_i[31:20]));
          end
        end
        SYSTEM: begin
          if (instr_i[14]) begin
            fmt = FMT_ZIMM;
            imm = XLEN'(instr_i[19:15]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr_i[31:20]));
          end
        end
        STORE: begin
          fmt = FMT_S;
          imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        end
        BRANCH: begin
          fmt   = FMT_B;
          pcrel = 1'b1;
          imm   = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                 instr_i[11:8], 1'b0}));
        end
        LUI: begin
          fmt = FMT_U;
          imm = XLEN'($signed({instr_i[31:12], 12'b0}));
        end
        AUIPC: begin
          fmt   = FMT_U;
          pcrel = 1'b1;
          imm   = XLEN'($signed({instr_i[31:12], 12'b0}));
        end
        JAL: begin
          fmt   = FMT_J;
          pcrel = 1'b1;
          imm   = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                 instr_i[30:21], 1'b0}));
        end
        OP: begin
          fmt = FMT_NONE;
        end
        default: begin
          ill = 1'b1;
        end
      endcase
    end
    // An undecodable word must not leak a partial immediate or a target
    if (ill) begin
      imm   = '0;
      fmt   = FMT_NONE;
      pcrel = 1'b0;
    end
  end

  assign imm_o      = imm;
  assign fmt_o      = fmt;
  assign illegal_o  = ill;
  assign is_pcrel_o = pcrel;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode + PC-relative target adder feeding a
// registered output stage with a 2-entry skid buffer, valid/ready and flush.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o,
  output logic [XLEN-1:0] target_o,
  output logic            illegal_o
);

  localparam int BW = 2 * XLEN + 4;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic            dec_pcrel;
  logic [XLEN-1:0] dec_target;
  logic [BW-1:0]   in_beat;

  logic [BW-1:0]   out_beat_q, out_beat_d;
  logic [BW-1:0]   skid_beat_q, skid_beat_d;
  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            accept;
  logic            drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i    (instr_i),
    .imm_o      (dec_imm),
    .fmt_o      (dec_fmt),
    .illegal_o  (dec_ill),
    .is_pcrel_o (dec_pcrel)
  );

  assign dec_target = dec_pcrel ? (pc_i + dec_imm) : '0;
  assign in_beat    = {dec_ill, dec_fmt, dec_target, dec_imm};

  // Skid entry is only ever occupied behind a valid, stalled output entry
  always_comb begin
    out_beat_d   = out_beat_q;
    skid_beat_d  = skid_beat_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid_i & in_ready_q;
    drain        = out_valid_q & out_ready_i;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_beat_d   = skid_beat_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_beat_d = in_beat;
        end
      end
    end else if (accept) begin
      skid_beat_d  = in_beat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_beat_q   <= '0;
      skid_beat_q  <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      out_beat_q   <= out_beat_d;
      skid_beat_q  <= skid_beat_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign {illegal_o, fmt_o, target_o, imm_o} = out_beat_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are compared against a queue-based behavioural model of the block.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  fmt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .instr_i(instr), .pc_i(pc[31:0]),
    .out_valid_o(ov32), .out_ready_i(out_ready), .imm_o(imm32),
    .fmt_o(fmt32), .target_o(tgt32), .illegal_o(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .instr_i(instr), .pc_i(pc),
    .out_valid_o(ov64), .out_ready_i(out_ready), .imm_o(imm64),
    .fmt_o(fmt64), .target_o(tgt64), .illegal_o(ill64)
  );

  // The driver must hold an offered beat steady until it is taken
  property p_hold_input;
    @(posedge clk) disable iff (rst)
      (in_valid && !rdy32 && !flush) |=> (in_valid && $stable(instr) && $stable(pc));
  endproperty
  assert property (p_hold_input) else $error("[TB] input hold rule violated");

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  bit   ready_m;
  bit   after_reset;
  bit   last_accepted;
  int   pass_count = 0;
  int   check_count = 0;

  function automatic longint sx(longint val, int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference decode straight from the field layout rules, using integer arithmetic
  function automatic exp_t refDecode(logic [31:0] ins, logic [63:0] p, int xlen);
    exp_t       e;
    longint     v = 0;
    int         f = 0;
    bit         ill = 0;
    bit         pcrel = 0;
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    if (ins[1:0] != 2'b11) begin
      ill = 1;
    end else begin
      case (opc)
        7'b0000011, 7'b0001111, 7'b1100111: begin
          f = 1; v = sx(longint'(ins[31:20]), 12);
        end
        7'b0010011: begin
          if (f3 == 3'd1 || f3 == 3'd5) begin
            f = 6;
            if (xlen == 32) begin
              ill = ins[25]; v = longint'(ins[24:20]);
            end else begin
              v = longint'(ins[25:20]);
            end
          end else begin
            f = 1; v = sx(longint'(ins[31:20]), 12);
          end
        end
        7'b1110011: begin
          if (f3 >= 3'd4) begin
            f = 7; v = longint'(ins[19:15]);
          end else begin
            f = 1; v = sx(longint'(ins[31:20]), 12);
          end
        end
        7'b0100011: begin
          f = 2; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
        end
        7'b1100011: begin
          f = 3; pcrel = 1;
          v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                 longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        end
        7'b0110111: begin
          f = 4; v = sx(longint'(ins[31:12]) * 4096, 32);
        end
        7'b0010111: begin
          f = 4; pcrel = 1; v = sx(longint'(ins[31:12]) * 4096, 32);
        end
        7'b1101111: begin
          f = 5; pcrel = 1;
          v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                 longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
        end
        7'b0110011: f = 0;
        default: ill = 1;
      endcase
    end
    if (ill) begin
      v = 0; f = 0; pcrel = 0;
    end
    e.imm = 64'(v);
    e.tgt = pcrel ? 64'(longint'(p) + v) : 64'd0;
    if (xlen == 32) begin
      e.imm = e.imm & 64'hFFFF_FFFF;
      e.tgt = e.tgt & 64'hFFFF_FFFF;
    end
    e.fmt = 3'(f);
    e.ill = ill;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, actual, expected, $time);
  endtask

  task automatic checkState();
    checkOutput("out_valid32", 64'(ov32), 64'(q32.size() > 0));
    checkOutput("in_ready32", 64'(rdy32), 64'(ready_m));
    checkOutput("out_valid64", 64'(ov64), 64'(q64.size() > 0));
    checkOutput("in_ready64", 64'(rdy64), 64'(ready_m));
    if (q32.size() > 0) begin
      checkOutput("imm32", 64'(imm32), q32[0].imm);
      checkOutput("fmt32", 64'(fmt32), 64'(q32[0].fmt));
      checkOutput("target32", 64'(tgt32), q32[0].tgt);
      checkOutput("illegal32", 64'(ill32), 64'(q32[0].ill));
      checkOutput("imm64", imm64, q64[0].imm);
      checkOutput("fmt64", 64'(fmt64), 64'(q64[0].fmt));
      checkOutput("target64", tgt64, q64[0].tgt);
      checkOutput("illegal64", 64'(ill64), 64'(q64[0].ill));
    end
    if (after_reset) begin
      checkOutput("rst_imm32", 64'(imm32), 64'd0);
      checkOutput("rst_fmt32", 64'(fmt32), 64'd0);
      checkOutput("rst_target32", 64'(tgt32), 64'd0);
      checkOutput("rst_illegal32", 64'(ill32), 64'd0);
      checkOutput("rst_imm64", imm64, 64'd0);
      checkOutput("rst_target64", tgt64, 64'd0);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] p,
                               input logic ordy, input logic fl, input logic rs);
    in_valid  = v;
    instr     = ins;
    pc        = p;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    last_accepted = v && ready_m && !fl && !rs;
    if (rs || fl) begin
      q32.delete();
      q64.delete();
      ready_m = !rs;
    end else begin
      if (q32.size() > 0 && ordy) begin
        void'(q32.pop_front());
        void'(q64.pop_front());
      end
      if (last_accepted) begin
        q32.push_back(refDecode(ins, p, 32));
        q64.push_back(refDecode(ins, p, 64));
      end
      ready_m = (q32.size() < 2);
    end
    after_reset = rs;
    @(posedge clk);
    @(negedge clk);
    checkState();
  endtask

  task automatic checkLiteral32(input string tag, input logic [31:0] e_imm,
                                input logic [2:0] e_fmt, input logic [31:0] e_tgt,
                                input logic e_ill);
    checkOutput({tag, "_valid"}, 64'(ov32), 64'd1);
    checkOutput({tag, "_imm"}, 64'(imm32), 64'(e_imm));
    checkOutput({tag, "_fmt"}, 64'(fmt32), 64'(e_fmt));
    checkOutput({tag, "_target"}, 64'(tgt32), 64'(e_tgt));
    checkOutput({tag, "_illegal"}, 64'(ill32), 64'(e_ill));
  endtask

  function automatic logic [31:0] genInstr();
    logic [6:0]  opcs [11] = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111,
                               7'b0100011, 7'b0110011, 7'b0110111, 7'b1100011,
                               7'b1100111, 7'b1101111, 7'b1110011};
    logic [31:0] r = $urandom;
    int          pick = $urandom_range(13);
    if (pick < 11) return {r[31:7], opcs[pick]};
    return r;
  endfunction

  logic [31:0] pend_instr;
  logic [63:0] pend_pc;
  bit          pend_v;
  bit          fl_r;
  bit          rs_r;
  bit          ordy_r;

  initial begin
    in_valid = 0; instr = '0; pc = '0; out_ready = 0; flush = 0; rst = 1;
    ready_m = 0; after_reset = 0; last_accepted = 0;

    applyStimulus(0, 32'h0, 64'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 64'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    $display("[TB] directed decode vectors");
    applyStimulus(1, 32'hFFC12083, 64'h100, 1, 0, 0);
    checkLiteral32("lw", 32'hFFFFFFFC, 3'd1, 32'h0, 1'b0);
    applyStimulus(1, 32'hFE000CE3, 64'h200, 1, 0, 0);
    checkLiteral32("beq", 32'hFFFFFFF8, 3'd3, 32'h1F8, 1'b0);
    applyStimulus(1, 32'h12345297, 64'h1000, 1, 0, 0);
    checkLiteral32("auipc", 32'h12345000, 3'd4, 32'h12346000, 1'b0);
    applyStimulus(1, 32'h123452B7, 64'h1000, 1, 0, 0);
    checkLiteral32("lui", 32'h12345000, 3'd4, 32'h0, 1'b0);
    applyStimulus(1, 32'h03F09093, 64'h0, 1, 0, 0);
    checkLiteral32("slli32", 32'h0, 3'd0, 32'h0, 1'b1);
    checkOutput("slli64_imm", imm64, 64'd63);
    checkOutput("slli64_fmt", 64'(fmt64), 64'd6);
    checkOutput("slli64_illegal", 64'(ill64), 64'd0);
    applyStimulus(1, 32'h0000007F, 64'h40, 1, 0, 0);
    checkLiteral32("badop", 32'h0, 3'd0, 32'h0, 1'b1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    $display("[TB] stall with four back-to-back beats");
    applyStimulus(1, 32'h00500093, 64'h10, 0, 0, 0);
    applyStimulus(1, 32'hFE000CE3, 64'h14, 0, 0, 0);
    checkOutput("stall_in_ready", 64'(rdy32), 64'd0);
    applyStimulus(1, 32'h12345297, 64'h18, 0, 0, 0);
    applyStimulus(1, 32'h12345297, 64'h18, 1, 0, 0);
    applyStimulus(1, 32'h12345297, 64'h18, 1, 0, 0);
    applyStimulus(1, 32'h0080006F, 64'h1C, 1, 0, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    $display("[TB] flush with two beats buffered");
    applyStimulus(1, 32'h00A00113, 64'h20, 0, 0, 0);
    applyStimulus(1, 32'h00B00193, 64'h24, 0, 0, 0);
    applyStimulus(1, 32'h00C00213, 64'h28, 0, 1, 0);
    checkOutput("flush_out_valid", 64'(ov32), 64'd0);
    checkOutput("flush_in_ready", 64'(rdy32), 64'd1);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    $display("[TB] randomized traffic");
    pend_v = 0;
    pend_instr = '0;
    pend_pc = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend_v && $urandom_range(99) < 60) begin
        pend_v     = 1;
        pend_instr = genInstr();
        pend_pc    = {$urandom, $urandom};
      end
      ordy_r = ($urandom_range(99) < 65);
      fl_r   = ($urandom_range(99) < 3);
      rs_r   = ($urandom_range(199) < 1);
      applyStimulus(pend_v, pend_instr, pend_pc, ordy_r, fl_r, rs_r);
      if (last_accepted || fl_r || rs_r) pend_v = 0;
    end
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 64'h0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
